shift_add_mult_seq: RTL and testbench

- Parametrised sequential shift-and-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
- Next generation of the 3-bit FSM multiplier: arbitrary width, signed/unsigned mode, start/busy/done handshake, early termination when the remaining multiplier bits are zero.
- Sits between operand registers and the result bus of the multiplier datapath; one multiplication in flight at a time.

---
 rtl/shift_add_mult_seq_if.sv | 25 ++
 rtl/shift_add_mult_seq.sv | 100 ++++++++++
 tb/tb_shift_add_mult_seq.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_seq_if.sv
// Start/busy/done handshake, operands and result of the sequential shift-and-add multiplier.
interface shift_add_mult_seq_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        iter_count;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, iter_count, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, iter_count, product
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned,
// one operation in flight, optional early finish once the remaining multiplier bits are zero.
module shift_add_mult_seq #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_add_mult_seq_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] b_sh;
  logic             b_neg;

  logic [PW-1:0]    acc_step;
  logic [WIDTH-1:0] b_next;
  logic [PW-1:0]    acc_fixed;
  logic             calc_last;

  // A negative multiplier keeps its MSB set until the last shift, so it never exits
  // early; a_ext has then been shifted exactly WIDTH times and equals A_ext_orig << WIDTH.
  always_comb begin
    acc_step  = b_sh[0] ? acc + a_ext : acc;
    b_next    = b_sh >> 1;
    acc_fixed = b_neg ? acc - a_ext : acc;
    calc_last = (bus.iter_count == CW'(1)) || (EARLY_EXIT && (b_next == '0));
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      a_ext          <= '0;
      acc            <= '0;
      b_sh           <= '0;
      b_neg          <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.iter_count <= '0;
      bus.product    <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_ext <= bus.signed_mode
                   ? {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                   : {{WIDTH{1'b0}}, bus.multiplicand};
            b_sh     <= bus.multiplier;
            b_neg    <= bus.signed_mode & bus.multiplier[WIDTH-1];
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          acc            <= '0;
          bus.iter_count <= CW'(WIDTH);
          state          <= CALC;
        end
        CALC: begin
          acc            <= acc_step;
          a_ext          <= a_ext << 1;
          b_sh           <= b_next;
          bus.iter_count <= bus.iter_count - CW'(1);
          if (calc_last) begin
            state <= FIX;
          end
        end
        FIX: begin
          acc            <= acc_fixed;
          bus.product    <= acc_fixed;
          bus.busy       <= 1'b0;
          bus.done       <= 1'b1;
          bus.iter_count <= '0;
          state          <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Scoreboard bench for shift_add_mult_seq: a WIDTH=3 instance without early exit and a
// WIDTH=8 instance with early exit, checked against an arithmetic reference.
module tb_shift_add_mult_seq;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [15:0] exp_q8 [$];
  logic [5:0]  exp_q3 [$];
  logic [7:0]  corner [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  shift_add_mult_seq_if #(.WIDTH(3)) bus3 ();
  shift_add_mult_seq_if #(.WIDTH(8)) bus8 ();

  shift_add_mult_seq #(.WIDTH(3), .EARLY_EXIT(1'b0)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );
  shift_add_mult_seq #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ae;
    logic [15:0] be;
    ae = s ? {{8{a[7]}}, a} : {8'h00, a};
    be = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ae * be;
  endfunction

  // Drives one request on the 8-bit instance and returns at the negedge where done is seen.
  // cyc counts negedges after the start negedge (0 = no done within the bound).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] expv, output int cyc, output logic [3:0] iter_prev);
    @(negedge clk);
    bus8.multiplicand = a;
    bus8.multiplier   = b;
    bus8.signed_mode  = s;
    bus8.start        = 1'b1;
    exp_q8.push_back(expv);
    cyc       = 0;
    iter_prev = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) bus8.start = 1'b0;
      if (bus8.done) begin
        cyc = n;
        break;
      end
      iter_prev = bus8.iter_count;
    end
  endtask

  task automatic check_prod8(input string name, input int cyc);
    logic [15:0] expv;
    expv = exp_q8.pop_front();
    total++;
    if (cyc == 0 || bus8.product !== expv) begin
      bad++;
      $display("FAIL %s: got product %h (done after %0d) want %h", name, bus8.product, cyc, expv);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus8.busy, bus8.done, bus8.iter_count, bus8.product} !== 22'd0) begin
      bad++;
      $display("FAIL reset8: got busy=%b done=%b iter=%0d product=%h want all zero",
               bus8.busy, bus8.done, bus8.iter_count, bus8.product);
    end
    total++;
    if ({bus3.busy, bus3.done, bus3.iter_count, bus3.product} !== 10'd0) begin
      bad++;
      $display("FAIL reset3: got busy=%b done=%b iter=%0d product=%h want all zero",
               bus3.busy, bus3.done, bus3.iter_count, bus3.product);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_w3_latency;
    int   done_at;
    logic busy_ok;
    logic [5:0] expv;
    @(negedge clk);
    bus3.multiplicand = 3'd7;
    bus3.multiplier   = 3'd7;
    bus3.signed_mode  = 1'b0;
    bus3.start        = 1'b1;
    exp_q3.push_back(6'b110001);
    done_at = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus3.start = 1'b0;
      if (bus3.done) begin
        done_at = n;
        break;
      end
      if (n >= 2 && bus3.busy !== 1'b1) busy_ok = 1'b0;
    end
    total++;
    if (done_at !== 6) begin
      bad++;
      $display("FAIL w3_latency: got done at %0d want 6", done_at);
    end
    total++;
    if (busy_ok !== 1'b1) begin
      bad++;
      $display("FAIL w3_busy: got busy low during calc want high");
    end
    expv = exp_q3.pop_front();
    total++;
    if (bus3.product !== expv || bus3.busy !== 1'b0 || bus3.iter_count !== 2'd0) begin
      bad++;
      $display("FAIL w3_product: got product=%b busy=%b iter=%0d want %b/0/0",
               bus3.product, bus3.busy, bus3.iter_count, expv);
    end
    @(negedge clk);
    total++;
    if (bus3.done !== 1'b0 || bus3.product !== expv) begin
      bad++;
      $display("FAIL w3_pulse: got done=%b product=%b want 0/%b", bus3.done, bus3.product, expv);
    end
  endtask

  task automatic test_signed;
    int cyc;
    logic [3:0] it;
    run8(8'h80, 8'hFF, 1'b1, 16'h0080, cyc, it);
    check_prod8("signed_m128_m1", cyc);
    total++;
    if (cyc !== 11) begin
      bad++;
      $display("FAIL signed_latency: got done at %0d want 11", cyc);
    end
    run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, cyc, it);
    check_prod8("signed_m3_5", cyc);
    run8(8'hFD, 8'h05, 1'b0, 16'h04F1, cyc, it);
    check_prod8("unsigned_253_5", cyc);
  endtask

  task automatic test_early_exit;
    int cyc;
    logic [3:0] it;
    run8(8'd200, 8'd3, 1'b0, 16'h0258, cyc, it);
    check_prod8("ee_200x3", cyc);
    total++;
    if (cyc !== 5 || it !== 4'd6) begin
      bad++;
      $display("FAIL ee_200x3_timing: got done at %0d iter %0d want 5 iter 6", cyc, it);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus8.product !== 16'h0258 || bus8.iter_count !== 4'd0 || bus8.busy !== 1'b0) begin
      bad++;
      $display("FAIL ee_hold: got product=%h iter=%0d busy=%b want 0258/0/0",
               bus8.product, bus8.iter_count, bus8.busy);
    end
    run8(8'd200, 8'd0, 1'b0, 16'h0000, cyc, it);
    check_prod8("ee_b0", cyc);
    total++;
    if (cyc !== 4) begin
      bad++;
      $display("FAIL ee_b0_timing: got done at %0d want 4", cyc);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [3:0] it;
    logic seen;
    run8(8'd9, 8'd9, 1'b0, 16'd81, cyc, it);
    check_prod8("pre_reset", cyc);
    @(negedge clk);
    bus8.multiplicand = 8'h55;
    bus8.multiplier   = 8'hAA;
    bus8.signed_mode  = 1'b0;
    bus8.start        = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b product=%h want 0/0/0000",
               bus8.busy, bus8.done, bus8.product);
    end
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: got activity after reset want none");
    end
    run8(8'd15, 8'd15, 1'b0, 16'd225, cyc, it);
    check_prod8("after_reset_15x15", cyc);
  endtask

  task automatic test_start_held;
    logic arm;
    int   dones;
    logic [7:0] a;
    logic [7:0] b;
    logic s;
    logic [15:0] expv;
    arm   = 1'b1;
    dones = 0;
    for (int n = 0; n < 300 && dones < 4; n++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      bus8.multiplicand = a;
      bus8.multiplier   = b;
      bus8.signed_mode  = s;
      bus8.start        = 1'b1;
      if (bus8.done) begin
        dones++;
        total++;
        if (exp_q8.size() == 0) begin
          bad++;
          $display("FAIL held_extra_done: got done with no accepted start");
        end else begin
          expv = exp_q8.pop_front();
          if (bus8.product !== expv) begin
            bad++;
            $display("FAIL held_product: got %h want %h", bus8.product, expv);
          end
        end
        arm = 1'b1;
      end else if (arm) begin
        exp_q8.push_back(ref8(a, b, s));
        arm = 1'b0;
      end
    end
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (dones !== 4 || exp_q8.size() !== 0 || bus8.busy !== 1'b0) begin
      bad++;
      $display("FAIL held_count: got dones=%0d pending=%0d busy=%b want 4/0/0",
               dones, exp_q8.size(), bus8.busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [3:0] it;
    logic seen;
    run8(8'd0, 8'd0, 1'b0, 16'd0, cyc, it);
    check_prod8("b2b_first", cyc);
    bus8.multiplicand = 8'd3;
    bus8.multiplier   = 8'd5;
    bus8.start        = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || bus8.product !== 16'd0) begin
      bad++;
      $display("FAIL start_in_done: got accepted (product %h) want ignored", bus8.product);
    end
    run8(8'h21, 8'h43, 1'b0, ref8(8'h21, 8'h43, 1'b0), cyc, it);
    check_prod8("b2b_a", cyc);
    run8(8'h12, 8'h01, 1'b1, 16'h0012, cyc, it);
    check_prod8("b2b_b", cyc);
    total++;
    if (cyc !== 4) begin
      bad++;
      $display("FAIL b2b_latency: got done at %0d want 4", cyc);
    end
  endtask

  task automatic test_sweep;
    int cyc;
    logic [3:0] it;
    logic [7:0] a;
    logic [7:0] b;
    logic s;
    for (int i = 0; i < 1000; i++) begin
      s = 1'(i % 2);
      if (i < 50) begin
        a = corner[(i / 2) / 5 % 5];
        b = corner[(i / 2) % 5];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      run8(a, b, s, ref8(a, b, s), cyc, it);
      check_prod8("sweep", cyc);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus3.start = 1'b0; bus3.signed_mode = 1'b0; bus3.multiplicand = '0; bus3.multiplier = '0;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;
    test_reset();
    test_w3_latency();
    test_signed();
    test_early_exit();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
